// File: rtl/ak_ctrl_regfile_pkg.sv
// Shared definitions for the AK control mailbox: register offsets, FSM states,
// AXI response codes and the timeout sentinel (used when AK_CTRL_TIMEOUT_EN is defined).
package ak_ctrl_regfile_pkg;

   typedef enum logic [7:0] {
      e_cmd_route    = 8'd0,
      e_cmd_code     = 8'd1,
      e_cmd_dat_resp = 8'd2,
      e_cmd_count    = 8'd3,
      e_status       = 8'd4,
      e_rsp_flag     = 8'd5
   } reg_off_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_WAIT_RSP = 2'd2
   } mbox_state_e;

   localparam logic [1:0]  RESP_OKAY        = 2'b00;
   localparam logic [1:0]  RESP_SLVERR      = 2'b10;
   localparam logic [31:0] TIMEOUT_SENTINEL = 32'hDEAD_0000;

   function automatic logic off_is(input logic [31:0] word_off, input reg_off_e off);
      return word_off == 32'(off);
   endfunction

endpackage

// File: rtl/ak_axil_slave_if.sv
// AXI4-Lite channel handshakes for the AK control mailbox: turns bus writes and
// reads into single-cycle wr_en/rd_en strobes and registers the B and R responses.
module ak_axil_slave_if
   import ak_ctrl_regfile_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   output logic              wr_en,
   output logic [ADDR_W-3:0] wr_addr,
   output logic [31:0]       wr_data,
   input  logic              wr_err_in,
   output logic              rd_en,
   output logic [ADDR_W-3:0] rd_addr,
   input  logic [31:0]       rd_data
);

   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q,  bresp_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q,  rdata_d;
   logic        wr_acc, rd_acc;
   logic        unused_lsb;

   assign unused_lsb = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   // Accept only when the previous response has drained, so at most one is outstanding.
   always_comb begin
      wr_acc   = !rst && s_axi_awvalid && s_axi_wvalid && !bvalid_q;
      rd_acc   = !rst && s_axi_arvalid && !rvalid_q;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      if (wr_acc) begin
         bvalid_d = 1'b1;
         bresp_d  = wr_err_in ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && s_axi_bready) begin
         bvalid_d = 1'b0;
         bresp_d  = RESP_OKAY;
      end
      if (rd_acc) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_data;
      end else if (rvalid_q && s_axi_rready) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bvalid_q <= 1'b0;
         bresp_q  <= RESP_OKAY;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign s_axi_awready = wr_acc;
   assign s_axi_wready  = wr_acc;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = rd_acc;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = RESP_OKAY;

   assign wr_en   = wr_acc;
   assign wr_addr = s_axi_awaddr[ADDR_W-1:2];
   assign wr_data = s_axi_wdata;
   assign rd_en   = rd_acc;
   assign rd_addr = s_axi_araddr[ADDR_W-1:2];

endmodule

// File: rtl/ak_ctrl_axil_responder.sv
// AXI4-Lite command mailbox to the AK decoder bus. Define AK_CTRL_TIMEOUT_EN to
// enable the WAIT_RSP response timeout (RSP_TIMEOUT cycles, reported in status[2]).
module ak_ctrl_axil_responder
   import ak_ctrl_regfile_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int RSP_TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [7:0]        cmd_route,
   output logic [31:0]       cmd_code,
   output logic [31:0]       cmd_data,
   input  logic              rsp_valid,
   input  logic [31:0]       rsp_data,
   input  logic              rsp_err
);

   logic              wr_en, wr_err_in, rd_en;
   logic [ADDR_W-3:0] wr_addr, rd_addr;
   logic [31:0]       wr_data, rd_data;
   logic [31:0]       wr_off, rd_off;

   mbox_state_e state_q, state_d;
   logic [7:0]  route_q, route_d;
   logic [31:0] code_q, code_d;
   logic [31:0] data_q, data_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic        timeout_q, timeout_d;
   logic        rsp_flag_q, rsp_flag_d;
   logic [7:0]  cmd_route_q, cmd_route_d;
   logic [31:0] cmd_code_q, cmd_code_d;
   logic [31:0] cmd_data_q, cmd_data_d;

   logic launch, busy, rsp_set, tmo_set, tmo_fire;

   ak_axil_slave_if #(.ADDR_W(ADDR_W)) u_axil (
      .clk           (clk),
      .rst           (rst),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_err_in     (wr_err_in),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data)
   );

   assign wr_off    = 32'(wr_addr);
   assign rd_off    = 32'(rd_addr);
   assign busy      = (state_q != ST_IDLE);
   assign wr_err_in = off_is(wr_off, e_cmd_dat_resp) && busy;
   assign launch    = wr_en && off_is(wr_off, e_cmd_dat_resp) && !busy;
   assign rsp_set   = (state_q == ST_WAIT_RSP) && rsp_valid;
   assign tmo_set   = (state_q == ST_WAIT_RSP) && tmo_fire && !rsp_valid;

`ifdef AK_CTRL_TIMEOUT_EN
   localparam int TMO_W = $clog2(RSP_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(RSP_TIMEOUT);
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

   // Counter only runs in WAIT_RSP and restarts from zero on every entry.
   always_comb begin
      tmo_cnt_d = '0;
      if (state_q == ST_WAIT_RSP) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) tmo_cnt_q <= '0;
      else     tmo_cnt_q <= tmo_cnt_d;
   end

   assign tmo_fire = (tmo_cnt_q == TMO_MAX);
`else
   logic unused_tmo;
   assign unused_tmo = (RSP_TIMEOUT == 0);
   assign tmo_fire   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:     if (launch) state_d = ST_ISSUE;
         ST_ISSUE:    if (cmd_ready) state_d = ST_WAIT_RSP;
         ST_WAIT_RSP: if (rsp_valid || tmo_fire) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      route_d     = route_q;
      code_d      = code_q;
      data_d      = data_q;
      cnt_d       = cnt_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      timeout_d   = timeout_q;
      rsp_flag_d  = rsp_flag_q;
      cmd_route_d = cmd_route_q;
      cmd_code_d  = cmd_code_q;
      cmd_data_d  = cmd_data_q;
      if (wr_en && off_is(wr_off, e_cmd_route)) route_d = wr_data[7:0];
      if (wr_en && off_is(wr_off, e_cmd_code))  code_d  = wr_data;
      // Launch-time copies keep cmd_* stable while software rewrites route/code.
      if (launch) begin
         data_d      = wr_data;
         cnt_d       = cnt_q + 16'd1;
         cmd_route_d = route_q;
         cmd_code_d  = code_q;
         cmd_data_d  = wr_data;
         rsp_flag_d  = 1'b0;
         timeout_d   = 1'b0;
         rsp_err_d   = 1'b0;
      end
      if (rd_en && off_is(rd_off, e_cmd_dat_resp)) rsp_flag_d = 1'b0;
      // A response landing in the same cycle as the clearing read wins.
      if (rsp_set) begin
         rsp_data_d = rsp_data;
         rsp_err_d  = rsp_err;
         rsp_flag_d = 1'b1;
      end
      if (tmo_set) begin
         rsp_data_d = TIMEOUT_SENTINEL;
         timeout_d  = 1'b1;
         rsp_flag_d = 1'b1;
      end
   end

   always_comb begin
      rd_data = '0;
      if      (off_is(rd_off, e_cmd_route))    rd_data = {24'd0, route_q};
      else if (off_is(rd_off, e_cmd_code))     rd_data = code_q;
      else if (off_is(rd_off, e_cmd_dat_resp)) rd_data = rsp_data_q;
      else if (off_is(rd_off, e_cmd_count))    rd_data = {16'd0, cnt_q};
      else if (off_is(rd_off, e_status))       rd_data = {29'd0, timeout_q, rsp_err_q, busy};
      else if (off_is(rd_off, e_rsp_flag))     rd_data = {31'd0, rsp_flag_q};
   end

   always_comb begin
      cmd_valid = (state_q == ST_ISSUE);
      cmd_route = cmd_route_q;
      cmd_code  = cmd_code_q;
      cmd_data  = cmd_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         route_q     <= '0;
         code_q      <= '0;
         data_q      <= '0;
         cnt_q       <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         timeout_q   <= 1'b0;
         rsp_flag_q  <= 1'b0;
         cmd_route_q <= '0;
         cmd_code_q  <= '0;
         cmd_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         route_q     <= route_d;
         code_q      <= code_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         timeout_q   <= timeout_d;
         rsp_flag_q  <= rsp_flag_d;
         cmd_route_q <= cmd_route_d;
         cmd_code_q  <= cmd_code_d;
         cmd_data_q  <= cmd_data_d;
      end
   end

endmodule

// File: tb/tb_ak_ctrl_axil_responder.sv
// Directed bench for ak_ctrl_axil_responder; the timeout scenario follows AK_CTRL_TIMEOUT_EN.
module tb_ak_ctrl_axil_responder;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] s_axi_awaddr;
   logic              s_axi_awvalid, s_axi_awready;
   logic [31:0]       s_axi_wdata;
   logic              s_axi_wvalid, s_axi_wready;
   logic [1:0]        s_axi_bresp;
   logic              s_axi_bvalid, s_axi_bready;
   logic [ADDR_W-1:0] s_axi_araddr;
   logic              s_axi_arvalid, s_axi_arready;
   logic [31:0]       s_axi_rdata;
   logic [1:0]        s_axi_rresp;
   logic              s_axi_rvalid, s_axi_rready;
   logic              cmd_valid, cmd_ready;
   logic [7:0]        cmd_route;
   logic [31:0]       cmd_code, cmd_data;
   logic              rsp_valid;
   logic [31:0]       rsp_data;
   logic              rsp_err;

   int          n_cmp = 0;
   int          n_err = 0;
   int          hs_cnt = 0;
   int          hs0;
   logic [7:0]  hs_route;
   logic [31:0] hs_code, hs_data;
   logic [31:0] rd_val;
   logic [1:0]  rd_resp;

   always #5 clk = ~clk;

   ak_ctrl_axil_responder #(.ADDR_W(ADDR_W), .RSP_TIMEOUT(100)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_route     (cmd_route),
      .cmd_code      (cmd_code),
      .cmd_data      (cmd_data),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err)
   );

   // Decoder-side monitor: what was actually handed over on each command handshake.
   always @(posedge clk) begin
      if (cmd_valid && cmd_ready) begin
         hs_cnt   <= hs_cnt + 1;
         hs_route <= cmd_route;
         hs_code  <= cmd_code;
         hs_data  <= cmd_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic axi_write(input logic [7:0] a, input logic [31:0] d, output logic [1:0] resp);
      int n;
      s_axi_awaddr = a; s_axi_wdata = d;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(s_axi_awready && s_axi_wready) && n < 20) begin @(negedge clk); n++; end
      check("aw_w_accept_in_time", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      n = 0;
      while (!s_axi_bvalid && n < 20) begin @(posedge clk); #1; n++; end
      check("bvalid_in_time", 32'(n < 20), 32'd1);
      resp = s_axi_bresp;
      s_axi_bready = 1'b1;
      @(posedge clk); #1;
      s_axi_bready = 1'b0;
   endtask

   task automatic axi_read(input logic [7:0] a, input logic inj, input logic [31:0] inj_word,
                           output logic [31:0] data, output logic [1:0] resp);
      int n;
      s_axi_araddr = a; s_axi_arvalid = 1'b1;
      if (inj) begin rsp_valid = 1'b1; rsp_data = inj_word; rsp_err = 1'b0; end
      n = 0;
      @(negedge clk);
      while (!s_axi_arready && n < 20) begin @(negedge clk); n++; end
      check("ar_accept_in_time", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0; rsp_valid = 1'b0;
      n = 0;
      while (!s_axi_rvalid && n < 20) begin @(posedge clk); #1; n++; end
      check("rvalid_in_time", 32'(n < 20), 32'd1);
      data = s_axi_rdata; resp = s_axi_rresp;
      s_axi_rready = 1'b1;
      @(posedge clk); #1;
      s_axi_rready = 1'b0;
   endtask

   task automatic wr_chk(input string tag, input logic [7:0] a, input logic [31:0] d, input logic [1:0] exp_resp);
      logic [1:0] r;
      axi_write(a, d, r);
      check(tag, 32'(r), 32'(exp_resp));
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic [1:0]  r;
      axi_read(a, 1'b0, 32'd0, d, r);
      check(tag, d, exp);
   endtask

   // Waits for cmd_valid, raises cmd_ready after rdy_dly cycles, then optionally strobes a response.
   task automatic dec_serve(input int rdy_dly, input int rsp_dly, input logic [31:0] word, input logic err);
      int n;
      n = 0;
      while (!cmd_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("cmd_valid_in_time", 32'(n < 50), 32'd1);
      repeat (rdy_dly) begin @(posedge clk); #1; end
      cmd_ready = 1'b1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;
      if (rsp_dly > 0) begin
         repeat (rsp_dly - 1) begin @(posedge clk); #1; end
         rsp_valid = 1'b1; rsp_data = word; rsp_err = err;
         @(posedge clk); #1;
         rsp_valid = 1'b0; rsp_err = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
      cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_awready", 32'(s_axi_awready), 32'd0);
      check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
      check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
      check("rst_bresp",   32'(s_axi_bresp),   32'd0);
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd_route", 32'(cmd_route), 32'd0);
      check("rst_cmd_data",  cmd_data, 32'd0);
      for (int i = 0; i < 6; i++) begin
         axi_read(8'(i * 4), 1'b0, 32'd0, rd_val, rd_resp);
         check($sformatf("rst_read_off%0d", i), rd_val, 32'd0);
         check($sformatf("rst_rresp_off%0d", i), 32'(rd_resp), 32'd0);
      end

      // Basic command with delayed ready and response
      wr_chk("wr_route_okay", 8'h00, 32'h0000_0023, 2'b00);
      wr_chk("wr_code_okay",  8'h04, 32'h0000_0027, 2'b00);
      wr_chk("wr_data_okay",  8'h08, 32'h3333_3327, 2'b00);
      check("cmd_valid_after_launch", 32'(cmd_valid), 32'd1);
      hs0 = hs_cnt;
      dec_serve(3, 50, 32'h1234_5678, 1'b0);
      check("hs_count_basic", 32'(hs_cnt - hs0), 32'd1);
      check("hs_route_basic", 32'(hs_route), 32'h23);
      check("hs_code_basic",  hs_code, 32'h27);
      check("hs_data_basic",  hs_data, 32'h3333_3327);
      check("cmd_valid_after_hs", 32'(cmd_valid), 32'd0);
      rd_chk("flag_set_basic",  8'h14, 32'd1);
      rd_chk("resp_basic",      8'h08, 32'h1234_5678);
      rd_chk("flag_clr_basic",  8'h14, 32'd0);
      rd_chk("count_basic",     8'h0C, 32'd1);
      rd_chk("status_basic",    8'h10, 32'd0);
      rd_chk("code_readback",   8'h04, 32'h27);
      wr_chk("wr_unmapped_okay", 8'h1C, 32'hFFFF_FFFF, 2'b00);
      rd_chk("rd_unmapped_zero", 8'h1C, 32'd0);

      // Second launch while busy is refused; route rewrite does not touch in-flight command
      pulse_rst();
      wr_chk("launch_okay",       8'h08, 32'hA5A5_0001, 2'b00);
      wr_chk("launch_busy_slverr", 8'h08, 32'hBBBB_BBBB, 2'b10);
      wr_chk("route_busy_okay",   8'h00, 32'hFFFF_FF5A, 2'b00);
      check("cmd_route_stable", 32'(cmd_route), 32'h00);
      check("cmd_data_stable",  cmd_data, 32'hA5A5_0001);
      rd_chk("count_after_slverr", 8'h0C, 32'd1);
      rd_chk("route_low8_only",    8'h00, 32'h5A);
      hs0 = hs_cnt;
      dec_serve(1, 5, 32'hCAFE_0003, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      check("hs_count_single", 32'(hs_cnt - hs0), 32'd1);
      check("hs_data_single",  hs_data, 32'hA5A5_0001);
      rd_chk("status_rsp_err", 8'h10, 32'h2);
      rd_chk("resp_err_word",  8'h08, 32'hCAFE_0003);

      // Read of the response register in the same cycle the response arrives
      wr_chk("launch3_okay", 8'h08, 32'h0000_0044, 2'b00);
      check("launch_clears_err", 32'(dut.rsp_err_q), 32'd0);
      dec_serve(1, 0, 32'd0, 1'b0);
      rd_chk("status_busy_wait", 8'h10, 32'h1);
      axi_read(8'h08, 1'b1, 32'h0BAD_F00D, rd_val, rd_resp);
      check("race_read_old_resp", rd_val, 32'hCAFE_0003);
      rd_chk("race_flag_set",   8'h14, 32'd1);
      rd_chk("race_status_idle", 8'h10, 32'd0);
      rd_chk("race_new_resp",   8'h08, 32'h0BAD_F00D);

`ifdef AK_CTRL_TIMEOUT_EN
      // Decoder accepts but never answers
      wr_chk("launch_tmo_okay", 8'h08, 32'h0000_0055, 2'b00);
      dec_serve(0, 0, 32'd0, 1'b0);
      repeat (120) @(posedge clk);
      #1;
      rd_chk("tmo_flag",   8'h14, 32'd1);
      rd_chk("tmo_status", 8'h10, 32'h4);
      rd_chk("tmo_resp",   8'h08, 32'hDEAD_0000);
`else
      // Without the timeout, WAIT_RSP holds indefinitely
      wr_chk("launch_notmo_okay", 8'h08, 32'h0000_0055, 2'b00);
      dec_serve(0, 0, 32'd0, 1'b0);
      repeat (120) @(posedge clk);
      #1;
      rd_chk("notmo_status_busy", 8'h10, 32'h1);
      rd_chk("notmo_flag",        8'h14, 32'd0);
      pulse_rst();
`endif

      // Reset during WAIT_RSP drops the command; a late response is ignored
      wr_chk("launch_rst_okay", 8'h08, 32'h0000_0066, 2'b00);
      dec_serve(0, 0, 32'd0, 1'b0);
      rd_chk("pre_rst_busy", 8'h10, 32'h1);
      pulse_rst();
      check("post_rst_cmd_valid", 32'(cmd_valid), 32'd0);
      rsp_valid = 1'b1; rsp_data = 32'h7777_7777; rsp_err = 1'b1;
      @(posedge clk); #1;
      rsp_valid = 1'b0; rsp_err = 1'b0;
      rd_chk("late_rsp_flag",   8'h14, 32'd0);
      rd_chk("late_rsp_status", 8'h10, 32'd0);
      rd_chk("late_rsp_resp",   8'h08, 32'd0);
      rd_chk("late_rsp_count",  8'h0C, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
